// File: rtl/aesl_monitor_pkg.sv
// Shared definitions for the AXI-stream deadlock monitors: FSM states,
// channel direction constants and a lowest-set-bit helper.
package aesl_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_LATCHED = 2'd2
   } mon_state_e;

   localparam bit DIR_IN  = 1'b1;
   localparam bit DIR_OUT = 1'b0;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic int lowest_set(input logic [31:0] v);
      int   idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (v[i] && !found) begin
            idx   = i;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/axis_block_sig_gen_if.sv
// Monitor-side bundle: observed TVALID/TREADY, control strobes and block report.
interface axis_block_sig_gen_if #(
   parameter int NUM_CH   = 8,
   parameter int CH_IDX_W = 3
);
   logic                enable;
   logic                clear_latch;
   logic [NUM_CH-1:0]   tvalid;
   logic [NUM_CH-1:0]   tready;
   logic [NUM_CH-1:0]   axis_block_sigs;
   logic                any_block;
   logic                first_block_valid;
   logic [CH_IDX_W-1:0] first_block_ch;

   modport slave (
      input  enable, clear_latch, tvalid, tready,
      output axis_block_sigs, any_block, first_block_valid, first_block_ch
   );

   modport master (
      output enable, clear_latch, tvalid, tready,
      input  axis_block_sigs, any_block, first_block_valid, first_block_ch
   );
endinterface

// File: rtl/axis_block_sig_gen_counter.sv
// One channel: stall decode, saturating run-length counter and registered block flag.
module axis_stall_counter
   import aesl_monitor_pkg::*;
#(
   parameter bit DIR    = DIR_IN,
   parameter int THRESH = 4
)(
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic tvalid,
   input  logic tready,
   output logic blk,
   output logic blk_nxt
);
   localparam int                CNT_W   = (THRESH < 1) ? 1 : $clog2(THRESH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESH);

   logic             stall;
   logic [CNT_W-1:0] cnt_p1;
   logic [CNT_W-1:0] cnt_nxt;
   logic             blk_p1;

   // Consumer side stalls when starved, producer side when back-pressured.
   assign stall = (DIR == DIR_IN) ? (tready & ~tvalid) : (tvalid & ~tready);

   always_comb begin
      cnt_nxt = '0;
      if (run && stall)
         cnt_nxt = (cnt_p1 == CNT_MAX) ? CNT_MAX : cnt_p1 + CNT_W'(1);
   end

   assign blk_nxt = (cnt_nxt == CNT_MAX);

   // Stage p1: counter and flag registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_p1 <= '0;
         blk_p1 <= 1'b0;
      end else begin
         cnt_p1 <= cnt_nxt;
         blk_p1 <= blk_nxt;
      end
   end

   assign blk = blk_p1;

endmodule

// File: rtl/axis_block_sig_gen.sv
// Per-channel AXI-stream block flags for the cosim deadlock monitors, with a
// latch recording the first channel to block.
module axis_block_sig_gen
   import aesl_monitor_pkg::*;
#(
   parameter int                NUM_CH       = 8,
   parameter logic [NUM_CH-1:0] DIR_MASK     = NUM_CH'(8'h0F),
   parameter int                STALL_THRESH = 4,
   parameter int                CH_IDX_W     = 3
)(
   input  logic                 clock,
   input  logic                 reset,
   axis_block_sig_gen_if.slave  mon
);
   mon_state_e          state;
   mon_state_e          state_nxt;
   logic                run;
   logic [NUM_CH-1:0]   blk;
   logic [NUM_CH-1:0]   blk_nxt;
   logic [NUM_CH-1:0]   rise;
   logic                any_p1;
   logic [CH_IDX_W-1:0] ch_p1;
   logic [CH_IDX_W-1:0] ch_nxt;
   logic [CH_IDX_W-1:0] rise_lo;

   // Counters only advance once the FSM has left IDLE.
   assign run = mon.enable && (state != ST_IDLE);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      axis_stall_counter #(
         .DIR    (DIR_MASK[i]),
         .THRESH (STALL_THRESH)
      ) u_cnt (
         .clock   (clock),
         .reset   (reset),
         .run     (run),
         .tvalid  (mon.tvalid[i]),
         .tready  (mon.tready[i]),
         .blk     (blk[i]),
         .blk_nxt (blk_nxt[i])
      );
   end

   assign rise    = blk_nxt & ~blk;
   assign rise_lo = CH_IDX_W'(lowest_set(32'(rise)));

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch_p1;
      if (!mon.enable) begin
         state_nxt = ST_IDLE;
         ch_nxt    = '0;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = ST_ARMED;
            ST_ARMED: begin
               if (|rise) begin
                  state_nxt = ST_LATCHED;
                  ch_nxt    = rise_lo;
               end
            end
            ST_LATCHED: begin
               // A clear colliding with a fresh rise re-arms straight onto the new channel.
               if (mon.clear_latch) begin
                  if (|rise) ch_nxt    = rise_lo;
                  else       state_nxt = ST_ARMED;
               end
            end
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Stage p1: FSM, latched index and aggregate flag
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= ST_IDLE;
         ch_p1  <= '0;
         any_p1 <= 1'b0;
      end else begin
         state  <= state_nxt;
         ch_p1  <= ch_nxt;
         any_p1 <= |blk_nxt;
      end
   end

   assign mon.axis_block_sigs   = blk;
   assign mon.any_block         = any_p1;
   assign mon.first_block_valid = (state == ST_LATCHED);
   assign mon.first_block_ch    = ch_p1;

endmodule

// File: tb/tb_axis_block_sig_gen.sv
// Bench for axis_block_sig_gen: directed vector table plus randomized traffic
// checked against a run-length reference model.
module tb_axis_block_sig_gen;
   localparam int         NUM_CH   = 8;
   localparam logic [7:0] DIR_MASK = 8'h0F;
   localparam int         THRESH   = 4;
   localparam int         CH_IDX_W = 3;

   logic clock;
   logic reset;

   axis_block_sig_gen_if #(.NUM_CH(NUM_CH), .CH_IDX_W(CH_IDX_W)) bus ();

   axis_block_sig_gen #(
      .NUM_CH       (NUM_CH),
      .DIR_MASK     (DIR_MASK),
      .STALL_THRESH (THRESH),
      .CH_IDX_W     (CH_IDX_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .mon   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests_run;
   int tests_failed;

   // Reference model: length of the current stall run per channel.
   int         m_run [NUM_CH];
   logic [7:0] m_flags;
   bit         m_active;
   bit         m_latched;
   int         m_ch;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       clr;
      logic [7:0] tv;
      logic [7:0] tr;
      int         cyc;
      logic [7:0] sigs;
      logic       vld;
      logic [2:0] ch;
      logic       chk_ch;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst_n, logic en, logic clr, logic [7:0] tv,
                               logic [7:0] tr, int cyc, logic [7:0] sigs,
                               logic vld, logic [2:0] ch, logic chk_ch);
      vec_t v;
      v.rst_n = rst_n; v.en = en; v.clr = clr; v.tv = tv; v.tr = tr; v.cyc = cyc;
      v.sigs = sigs; v.vld = vld; v.ch = ch; v.chk_ch = chk_ch;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [7:0] newf;
      logic [7:0] rise;
      int         lo;
      bit         st;
      if (!reset || !bus.enable) begin
         m_active  = 1'b0;
         m_latched = 1'b0;
         m_ch      = 0;
         m_flags   = '0;
         for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      end else if (!m_active) begin
         m_active = 1'b1;
      end else begin
         newf = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (DIR_MASK[i]) st = bus.tready[i] && !bus.tvalid[i];
            else             st = bus.tvalid[i] && !bus.tready[i];
            m_run[i] = st ? m_run[i] + 1 : 0;
            if (m_run[i] > 1000) m_run[i] = 1000;
            newf[i] = (m_run[i] >= THRESH);
         end
         rise = newf & ~m_flags;
         lo = -1;
         for (int i = NUM_CH - 1; i >= 0; i--) if (rise[i]) lo = i;
         if (m_latched) begin
            if (bus.clear_latch) begin
               if (lo >= 0) m_ch = lo;
               else         m_latched = 1'b0;
            end
         end else if (lo >= 0) begin
            m_latched = 1'b1;
            m_ch      = lo;
         end
         m_flags = newf;
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      chk("model_sigs",  32'(bus.axis_block_sigs),   32'(m_flags));
      chk("model_any",   32'(bus.any_block),         32'(m_flags != 0));
      chk("model_valid", 32'(bus.first_block_valid), 32'(m_latched));
      chk("model_ch",    32'(bus.first_block_ch),    32'(m_ch));
   endtask

   task automatic apply(input vec_t v);
      reset           = v.rst_n;
      bus.enable      = v.en;
      bus.clear_latch = v.clr;
      bus.tvalid      = v.tv;
      bus.tready      = v.tr;
      for (int c = 0; c < v.cyc; c++) step();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      m_flags      = '0;
      m_active     = 1'b0;
      m_latched    = 1'b0;
      m_ch         = 0;
      for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
      reset           = 1'b0;
      bus.enable      = 1'b0;
      bus.clear_latch = 1'b0;
      bus.tvalid      = '0;
      bus.tready      = '0;

      // Reset with every channel stalling, then release and re-arm.
      tbl.push_back(mk(0,1,0,8'hF0,8'h0F,2, 8'h00,0,0,1));
      tbl.push_back(mk(1,1,0,8'hF0,8'h0F,4, 8'h00,0,0,1));
      tbl.push_back(mk(1,1,0,8'hF0,8'h0F,1, 8'hFF,1,0,1));
      // Enable drop while everything is flagged.
      tbl.push_back(mk(1,0,0,8'hF0,8'h0F,1, 8'h00,0,0,1));
      tbl.push_back(mk(1,1,0,8'hF0,8'h0F,4, 8'h00,0,0,1));
      tbl.push_back(mk(1,1,0,8'hF0,8'h0F,1, 8'hFF,1,0,1));
      tbl.push_back(mk(1,1,0,8'h00,8'h00,1, 8'h00,1,0,1));
      tbl.push_back(mk(1,1,1,8'h00,8'h00,1, 8'h00,0,0,0));
      // ch0 input starvation: 3 stalls + handshake, then a full run.
      tbl.push_back(mk(1,1,0,8'h00,8'h01,3, 8'h00,0,0,0));
      tbl.push_back(mk(1,1,0,8'h01,8'h01,1, 8'h00,0,0,0));
      tbl.push_back(mk(1,1,0,8'h00,8'h01,3, 8'h00,0,0,0));
      tbl.push_back(mk(1,1,0,8'h00,8'h01,1, 8'h01,1,0,1));
      tbl.push_back(mk(1,1,0,8'h00,8'h00,1, 8'h00,1,0,1));
      tbl.push_back(mk(1,1,1,8'h00,8'h00,1, 8'h00,0,0,0));
      // ch5 output back-pressure for 10 cycles, recovery, restart from zero.
      tbl.push_back(mk(1,1,0,8'h20,8'h00,3, 8'h00,0,0,0));
      tbl.push_back(mk(1,1,0,8'h20,8'h00,1, 8'h20,1,5,1));
      tbl.push_back(mk(1,1,0,8'h20,8'h00,6, 8'h20,1,5,1));
      tbl.push_back(mk(1,1,0,8'h20,8'h20,1, 8'h00,1,5,1));
      tbl.push_back(mk(1,1,0,8'h20,8'h00,3, 8'h00,1,5,1));
      tbl.push_back(mk(1,1,0,8'h20,8'h00,1, 8'h20,1,5,1));
      tbl.push_back(mk(1,1,0,8'h00,8'h00,1, 8'h00,1,5,1));
      tbl.push_back(mk(1,1,1,8'h00,8'h00,1, 8'h00,0,0,0));
      // ch6 and ch2 together, ch7 later, then clear colliding with ch3 rise.
      tbl.push_back(mk(1,1,0,8'h40,8'h04,3, 8'h00,0,0,0));
      tbl.push_back(mk(1,1,0,8'h40,8'h04,1, 8'h44,1,2,1));
      tbl.push_back(mk(1,1,0,8'hC0,8'h04,3, 8'h44,1,2,1));
      tbl.push_back(mk(1,1,0,8'hC0,8'h04,1, 8'hC4,1,2,1));
      tbl.push_back(mk(1,1,0,8'hC0,8'h0C,3, 8'hC4,1,2,1));
      tbl.push_back(mk(1,1,1,8'hC0,8'h0C,1, 8'hCC,1,3,1));
      tbl.push_back(mk(1,1,1,8'hC0,8'h0C,1, 8'hCC,0,0,0));
      tbl.push_back(mk(1,1,0,8'h00,8'h00,1, 8'h00,0,0,0));

      for (int r = 0; r < tbl.size(); r++) begin
         apply(tbl[r]);
         chk($sformatf("row%0d_sigs", r),  32'(bus.axis_block_sigs),   32'(tbl[r].sigs));
         chk($sformatf("row%0d_any", r),   32'(bus.any_block),         32'(tbl[r].sigs != 0));
         chk($sformatf("row%0d_valid", r), 32'(bus.first_block_valid), 32'(tbl[r].vld));
         if (tbl[r].chk_ch)
            chk($sformatf("row%0d_ch", r), 32'(bus.first_block_ch),    32'(tbl[r].ch));
      end

      // Randomized traffic biased toward stalls, with rare enable drops, clears and resets.
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] tv;
         logic [7:0] tr;
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 7) < 5) begin
               tv[i] = !DIR_MASK[i];
               tr[i] = DIR_MASK[i];
            end else begin
               tv[i] = 1'($urandom_range(0, 1));
               tr[i] = 1'($urandom_range(0, 1));
            end
         end
         reset           = ($urandom_range(0, 255) != 0);
         bus.enable      = ($urandom_range(0, 63) != 0);
         bus.clear_latch = ($urandom_range(0, 15) == 0);
         bus.tvalid      = tv;
         bus.tready      = tr;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axis_block_sig_gen.md
Name: axis_block_sig_gen

Overview:
- Producer of the per-channel `axis_block_sigs` vector consumed by the cosim deadlock monitors.
- Watches TVALID/TREADY of each AXI-stream port on the DUT boundary.
- Flags a channel as blocked after a programmable run of consecutive stall cycles.
- Latches the first channel to block, as a diagnostic for the testbench deadlock reporter.

Parameters:
- NUM_CH, 8: number of monitored AXI-stream channels (1..32).
- DIR_MASK, 8'h0F: bit i = 1 means channel i is a DUT input (DUT consumes); 0 means DUT output (DUT produces).
- STALL_THRESH, 4: consecutive stall cycles before a block flag asserts (>= 1).
- CH_IDX_W, 3: width of the channel index output; must equal max(1, clog2(NUM_CH)).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- enable  in  1  monitoring enable; 0 forces IDLE.
- clear_latch  in  1  single-cycle pulse; releases the first-block latch.
- tvalid  in  NUM_CH  per-channel TVALID.
- tready  in  NUM_CH  per-channel TREADY.
- axis_block_sigs  out  NUM_CH  registered per-channel block flags.
- any_block  out  1  registered OR of axis_block_sigs.
- first_block_valid  out  1  high while the first-block latch holds a channel.
- first_block_ch  out  CH_IDX_W  index of the first channel to block.

Behaviour:
- Reset (reset==0 at an edge):
  - State = IDLE.
  - All counters = 0; axis_block_sigs = 0; any_block = 0; first_block_valid = 0; first_block_ch = 0.
  - A reset asserted mid-operation discards all stall history.
- Stall condition per channel i:
  - DIR_MASK[i]=1 (input starved): stall_i = tready[i] & ~tvalid[i].
  - DIR_MASK[i]=0 (output back-pressured): stall_i = tvalid[i] & ~tready[i].
  - A handshake (tvalid & tready), or both low, is not a stall.
- Counter per channel: width clog2(STALL_THRESH+1).
  - While monitoring: if stall_i, cnt_i <= min(cnt_i+1, STALL_THRESH); else cnt_i <= 0.
  - Saturates at STALL_THRESH and never wraps.
- Block flag timing:
  - axis_block_sigs[i] rises on the edge that ends the STALL_THRESH-th consecutive stall cycle. With STALL_THRESH=1 it rises after a single stall cycle.
  - It falls on the edge ending the first non-stall cycle; the counter clears on that same edge.
- any_block is registered from the next-state block vector, so it is coincident with axis_block_sigs.
- FSM states:
  - IDLE: counters and flags held at 0; latch cleared. Goes to ARMED when enable=1.
  - ARMED: counting. On any rising block flag: go to LATCHED and capture its index. If several rise on the same edge, capture the lowest index.
  - LATCHED: counting continues; first_block_valid=1; first_block_ch frozen.
    - clear_latch=1 with no new rise: go to ARMED, valid <= 0.
    - clear_latch=1 with a rise on the same edge: stay LATCHED and capture the lowest newly rising index.
  - Any state, enable=0: go to IDLE; all outputs 0 on the next edge.
- Timing: latency from stall onset to flag is exactly STALL_THRESH cycles. No combinational path from inputs to outputs.

Decomposition:
- Shared package `aesl_monitor_pkg`:
  - FSM state enum (IDLE, ARMED, LATCHED).
  - Direction constants DIR_IN=1, DIR_OUT=0.
  - Function for the lowest-set-bit index.
- One natural sub-module, `axis_stall_counter`: per-channel stall decode, saturating counter and registered flag, instantiated NUM_CH times via generate. The top level holds the FSM, the priority encoder and any_block.

Test Plan:
- Reset: reset=0 for 2 cycles with every channel driving a stall -> all outputs 0 and state IDLE throughout. Release with enable=1 -> flags appear only after 4 further stall cycles.
- Threshold and input direction: ch0 (DIR_IN), tready=1, tvalid=0 for 4 cycles -> axis_block_sigs=8'h01, any_block=1, first_block_ch=0, first_block_valid=1 after exactly 4 edges. A 3-cycle stall followed by a handshake -> no flag.
- Output direction and recovery: ch5 (DIR_OUT), tvalid=1, tready=0 for 10 cycles -> bit 5 high from cycle 4 to 10. tready=1 at cycle 11 -> bit 5 low on the following edge; counter restarts from 0.
- Simultaneous rise: ch6 and ch2 stall starting the same cycle -> axis_block_sigs=8'h44, first_block_ch=2. ch7 rising later leaves first_block_ch=2.
- Clear collision: in LATCHED with ch2, pulse clear_latch on the same edge ch3 rises -> first_block_ch=3, first_block_valid stays 1. Pulse clear_latch with no rise -> valid=0, state ARMED.
- Enable drop: while 8'hFF is flagged, enable=0 for 1 cycle -> all outputs 0 next edge. Re-enable with stalls held -> flags return only after 4 cycles.
